// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: HH:MM time-of-day controller for a four-digit multiplexed
// seven-segment clock.
//   Keeps BCD time plus an internal seconds count. A mode FSM cycles
//   RUN -> SET_HOUR -> SET_MIN -> RUN on debounced mode-button presses.
//   It also drives the digit scan: BCD digit, active-low enables and edit blink.
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   tick_1s, tick_scan    one-cycle pulses: once per second / digit-scan rate
//   btn_mode, btn_inc     raw active-high buttons, asynchronous to clock
//   bcd[3:0]              BCD value of the scanned digit
//   K[3:0]                active-low digit enables (0=min1 .. 3=hour10)
//   blank                 scanned digit suppressed by the edit blink
//   mode[1:0]             FSM state (00 RUN, 01 SET_HOUR, 10 SET_MIN)
//   hour10..min1          BCD time registers
// Handshake: none. tick_1s, tick_scan and the internal press pulses are
// single-cycle strobes that are acted on in the cycle they are high.
module clock_set_ctrl #(
  parameter int DB_TICKS    = 4,
  parameter int BLINK_SCANS = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       tick_scan,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] bcd,
  output logic [3:0] K,
  output logic       blank,
  output logic [1:0] mode,
  output logic [3:0] hour10,
  output logic [3:0] hour1,
  output logic [3:0] min10,
  output logic [3:0] min1
);

  localparam int DBW = $clog2(DB_TICKS + 1);
  localparam int BLW = $clog2(BLINK_SCANS + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10,
    ST_BAD      = 2'b11
  } state_e;

  state_e state_q, state_d;

  // Button path, bit 0 = mode, bit 1 = inc.
  logic [1:0]     sync1_q, sync2_q, lvl_q, lvl_prev_q;
  logic [DBW-1:0] db_cnt_q [2];
  logic [1:0]     press;
  logic           mode_p, inc_p, inc_acc;

  logic [5:0] sec_q, sec_d;
  logic [3:0] h10_q, h1_q, m10_q, m1_q;
  logic [3:0] h10_d, h1_d, m10_d, m1_d;

  logic [1:0]     idx_q;
  logic [BLW-1:0] blink_cnt_q, blink_cnt_d;
  logic           phase_q, phase_d;
  logic [3:0]     k_sel;

  // Synchronizer and debouncer: a new level is accepted only after
  // DB_TICKS consecutive scan-tick samples that all differ from the current one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
    end else begin
      sync1_q    <= {btn_inc, btn_mode};
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      for (int b = 0; b < 2; b++) begin
        if (tick_scan) begin
          if (sync2_q[b] != lvl_q[b]) begin
            if (db_cnt_q[b] == DBW'(DB_TICKS - 1)) begin
              lvl_q[b]    <= sync2_q[b];
              db_cnt_q[b] <= '0;
            end else begin
              db_cnt_q[b] <= db_cnt_q[b] + DBW'(1);
            end
          end else begin
            db_cnt_q[b] <= '0;
          end
        end
      end
    end
  end

  assign press  = lvl_q & ~lvl_prev_q;
  assign mode_p = press[0];
  assign inc_p  = press[1];
  // A mode press in the same cycle swallows the increment.
  assign inc_acc = inc_p & ~mode_p &
                   ((state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (mode_p) state_d = ST_SET_HOUR;
      ST_SET_HOUR: if (mode_p) state_d = ST_SET_MIN;
      ST_SET_MIN:  if (mode_p) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // Hours 00..23 in BCD.
  function automatic logic [7:0] inc_hour(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd2 && o == 4'd3) return 8'h00;
    else if (o == 4'd9)         return {t + 4'd1, 4'd0};
    else                        return {t, o + 4'd1};
  endfunction

  // Minutes 00..59 in BCD; bit 8 flags the wrap to 00.
  function automatic logic [8:0] inc_min(input logic [3:0] t, input logic [3:0] o);
    if (o != 4'd9)      return {1'b0, t, o + 4'd1};
    else if (t == 4'd5) return 9'h100;
    else                return {1'b0, t + 4'd1, 4'd0};
  endfunction

  always_comb begin
    sec_d = sec_q;
    h10_d = h10_q;
    h1_d  = h1_q;
    m10_d = m10_q;
    m1_d  = m1_q;
    // Seconds are only counted from the pre-edge RUN state.
    if (state_q == ST_RUN && tick_1s) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        {m10_d, m1_d} = inc_min(m10_q, m1_q)[7:0];
        if (inc_min(m10_q, m1_q)[8]) {h10_d, h1_d} = inc_hour(h10_q, h1_q);
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
    if (state_q == ST_SET_MIN && mode_p) sec_d = '0;
    if (inc_acc) begin
      if (state_q == ST_SET_HOUR) {h10_d, h1_d} = inc_hour(h10_q, h1_q);
      else                        {m10_d, m1_d} = inc_min(m10_q, m1_q)[7:0];
    end
  end

  // Blink restarts visible whenever the user does something.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (state_d != state_q || inc_acc) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (tick_scan) begin
      if (blink_cnt_q == BLW'(BLINK_SCANS - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      sec_q       <= '0;
      h10_q       <= '0;
      h1_q        <= '0;
      m10_q       <= '0;
      m1_q        <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      h10_q       <= h10_d;
      h1_q        <= h1_d;
      m10_q       <= m10_d;
      m1_q        <= m1_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      if (tick_scan) idx_q <= idx_q + 2'd1;
    end
  end

  always_comb begin
    bcd   = m1_q;
    k_sel = 4'b1110;
    case (idx_q)
      2'd0: begin bcd = m1_q;  k_sel = 4'b1110; end
      2'd1: begin bcd = m10_q; k_sel = 4'b1101; end
      2'd2: begin bcd = h1_q;  k_sel = 4'b1011; end
      default: begin bcd = h10_q; k_sel = 4'b0111; end
    endcase
    blank = phase_q & (((state_q == ST_SET_HOUR) &&  idx_q[1]) ||
                       ((state_q == ST_SET_MIN)  && !idx_q[1]));
    K = blank ? 4'b1111 : k_sel;
  end

  assign mode   = state_q;
  assign hour10 = h10_q;
  assign hour1  = h1_q;
  assign min10  = m10_q;
  assign min1   = m1_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl: table-driven vectors plus hand sequences
// for the button, blink and reset corner cases.
module tb_clock_set_ctrl;
  localparam int DB_TICKS    = 4;
  localparam int BLINK_SCANS = 250;

  logic       clock = 1'b0;
  logic       reset, tick_1s, tick_scan, btn_mode, btn_inc;
  logic [3:0] bcd, K, hour10, hour1, min10, min1;
  logic       blank;
  logic [1:0] mode;

  clock_set_ctrl #(.DB_TICKS(DB_TICKS), .BLINK_SCANS(BLINK_SCANS)) dut (
    .clock(clock), .reset(reset), .tick_1s(tick_1s), .tick_scan(tick_scan),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .bcd(bcd), .K(K), .blank(blank),
    .mode(mode), .hour10(hour10), .hour1(hour1), .min10(min10), .min1(min1)
  );

  always #5 clock = ~clock;

  typedef struct { int n; logic [15:0] t; } tick_vec_t;
  typedef struct { logic [3:0] k; logic [3:0] d; logic b; } disp_vec_t;

  int          checks = 0;
  int          errors = 0;
  int          scan_idx = 0;
  logic [15:0] exp_q[$];
  tick_vec_t   tv[4];
  disp_vec_t   run_0100[4], run_2359[4], blink_2359[4];

  function automatic logic [15:0] time_now();
    return {hour10, hour1, min10, min1};
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic scan();
    tick_scan = 1'b1; step(1); tick_scan = 1'b0; step(1);
    scan_idx = (scan_idx + 1) % 4;
  endtask

  task automatic sec_tick();
    tick_1s = 1'b1; step(1); tick_1s = 1'b0; step(1);
  endtask

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string name, input logic [15:0] act);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h, nothing expected in queue", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  task automatic expect_time(input string name, input logic [15:0] t);
    push(t); pop_check(name, time_now());
  endtask

  task automatic expect_mode(input string name, input logic [1:0] m);
    push({14'd0, m}); pop_check(name, {14'd0, mode});
  endtask

  task automatic expect_disp(input string name, input disp_vec_t v);
    push({7'd0, v.b, v.d, v.k}); pop_check(name, {7'd0, blank, bcd, K});
  endtask

  // Press and release with full synchronizer + debounce settling each way.
  task automatic press(input logic m, input logic i);
    btn_mode = m; btn_inc = i; step(3);
    repeat (DB_TICKS) scan();
    step(2);
    btn_mode = 1'b0; btn_inc = 1'b0; step(3);
    repeat (DB_TICKS) scan();
    step(2);
  endtask

  task automatic do_reset();
    reset = 1'b1; step(2); reset = 1'b0; scan_idx = 0; step(1);
  endtask

  initial begin
    tv[0] = '{59, 16'h0000};
    tv[1] = '{1, 16'h0001};
    tv[2] = '{540, 16'h0010};
    tv[3] = '{3000, 16'h0100};
    run_0100[0] = '{4'b1110, 4'd0, 1'b0};
    run_0100[1] = '{4'b1101, 4'd0, 1'b0};
    run_0100[2] = '{4'b1011, 4'd1, 1'b0};
    run_0100[3] = '{4'b0111, 4'd0, 1'b0};
    run_2359[0] = '{4'b1110, 4'd9, 1'b0};
    run_2359[1] = '{4'b1101, 4'd5, 1'b0};
    run_2359[2] = '{4'b1011, 4'd3, 1'b0};
    run_2359[3] = '{4'b0111, 4'd2, 1'b0};
    blink_2359[0] = '{4'b1111, 4'd9, 1'b1};
    blink_2359[1] = '{4'b1111, 4'd5, 1'b1};
    blink_2359[2] = '{4'b1011, 4'd3, 1'b0};
    blink_2359[3] = '{4'b0111, 4'd2, 1'b0};

    tick_1s = 1'b0; tick_scan = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    do_reset();

    // Reset state
    expect_time("reset_time", 16'h0000);
    expect_mode("reset_mode", 2'b00);
    expect_disp("reset_disp", run_0100[0] /* K=1110 bcd=0 blank=0 */);

    // Running clock: cumulative seconds against expected HH:MM
    for (int k = 0; k < 4; k++) begin
      repeat (tv[k].n) sec_tick();
      expect_time($sformatf("run_ticks_%0d", k), tv[k].t);
    end

    // Digit scan at 01:00
    for (int k = 0; k < 4; k++) begin
      expect_disp($sformatf("scan_0100_idx%0d", scan_idx), run_0100[scan_idx]);
      scan();
    end

    // Fresh start; leave 30 s pending so the exit from SET_MIN must clear them
    do_reset();
    repeat (30) sec_tick();
    expect_time("sec30_time", 16'h0000);
    press(1'b1, 1'b0);
    expect_mode("to_set_hour", 2'b01);

    // 25 increments with tick_1s held high: frozen time, hours wrap to 01
    tick_1s = 1'b1;
    repeat (25) press(1'b0, 1'b1);
    tick_1s = 1'b0; step(2);
    expect_mode("inc25_mode", 2'b01);
    expect_time("inc25_time", 16'h0100);

    repeat (22) press(1'b0, 1'b1);
    expect_time("hour_23", 16'h2300);
    press(1'b0, 1'b1);
    expect_time("hour_wrap", 16'h0000);
    repeat (23) press(1'b0, 1'b1);
    expect_time("hour_back_23", 16'h2300);

    press(1'b1, 1'b0);
    expect_mode("to_set_min", 2'b10);
    repeat (59) press(1'b0, 1'b1);
    expect_time("min_59", 16'h2359);

    // Blink: scans since the last accepted inc reach BLINK_SCANS here
    repeat (BLINK_SCANS - DB_TICKS) scan();
    for (int k = 0; k < 4; k++) begin
      expect_disp($sformatf("blink_idx%0d", scan_idx), blink_2359[scan_idx]);
      scan();
    end

    // Minute wrap without hour carry; the inc also forces digits visible
    press(1'b0, 1'b1);
    expect_time("min_wrap", 16'h2300);
    for (int k = 0; k < 3 && scan_idx != 0; k++) scan();
    push({7'd0, 1'b0, 4'd0, 4'b1110});
    pop_check("visible_after_inc", {7'd0, blank, bcd, K});

    repeat (59) press(1'b0, 1'b1);
    expect_time("min_59_again", 16'h2359);
    press(1'b1, 1'b0);
    expect_mode("back_to_run", 2'b00);

    for (int k = 0; k < 4; k++) begin
      expect_disp($sformatf("scan_2359_idx%0d", scan_idx), run_2359[scan_idx]);
      scan();
    end

    // Seconds restarted at 0 on leaving SET_MIN
    repeat (59) sec_tick();
    expect_time("rollover_59s", 16'h2359);
    sec_tick();
    expect_time("rollover_day", 16'h0000);
    expect_mode("rollover_mode", 2'b00);

    // Bouncing inc then a steady hold: exactly one increment
    press(1'b1, 1'b0);
    expect_mode("bounce_mode", 2'b01);
    for (int k = 0; k < 10; k++) begin
      btn_inc = ~btn_inc;
      scan();
    end
    btn_inc = 1'b1; step(3);
    repeat (DB_TICKS + 2) scan();
    btn_inc = 1'b0; step(3);
    repeat (DB_TICKS) scan();
    step(2);
    expect_time("bounce_one_inc", 16'h0100);

    // Simultaneous mode + inc: mode wins
    press(1'b1, 1'b1);
    expect_mode("simul_mode", 2'b10);
    expect_time("simul_time", 16'h0100);

    repeat (3) press(1'b0, 1'b1);
    expect_time("set_min_3", 16'h0103);

    // Asynchronous reset between clock edges
    @(posedge clock); #2;
    reset = 1'b1; #1;
    expect_mode("async_rst_mode", 2'b00);
    expect_time("async_rst_time", 16'h0000);
    push({7'd0, 1'b0, 4'd0, 4'b1110});
    pop_check("async_rst_disp", {7'd0, blank, bcd, K});
    step(1);
    reset = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-of-day controller for the HH:MM seven-segment clock. It keeps the BCD time, and a mode FSM sequences it through RUN, SET_HOUR and SET_MIN. The FSM takes debounced button presses from the board buttons. The block also schedules the four-digit multiplexed display, driving the BCD digit, the active-low digit enables and the edit-field blink. It sits between the tick generators (1 s, scan rate) and the BCD-to-seven-segment decoder.

## Interface
- `DB_TICKS`, 4: consecutive identical `tick_scan` samples required to accept a new button level.
- `BLINK_SCANS`, 250: `tick_scan` pulses per blink half-period.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `tick_1s`  in  1  one-cycle pulse, once per second.
- `tick_scan`  in  1  one-cycle pulse at digit-scan rate.
- `btn_mode`  in  1  raw mode button, active-high, asynchronous to `clock`.
- `btn_inc`  in  1  raw increment button, active-high, asynchronous.
- `bcd`  out  4  BCD value of the currently scanned digit.
- `K`  out  4  active-low digit enables: K[0]=min1, K[1]=min10, K[2]=hour1, K[3]=hour10.
- `blank`  out  1  high when the scanned digit is suppressed by blink.
- `mode`  out  2  FSM state: 00 RUN, 01 SET_HOUR, 10 SET_MIN (11 unused).
- `hour10`, `hour1`, `min10`, `min1`  out  4 each  BCD time registers.

## Operation
- **Buttons**
  - Each button passes through a 2-flop synchronizer and then a debouncer.
  - The debounced level changes only after `DB_TICKS` consecutive `tick_scan` samples that all equal the new level.
  - A debounced 0→1 transition yields a one-cycle press pulse (`mode_p`, `inc_p`). Releases produce nothing.
- **FSM transitions on `mode_p`:** RUN→SET_HOUR→SET_MIN→RUN.
  - The SET_MIN→RUN transition clears seconds to 0.
  - State 11 is unreachable; if entered, it returns to RUN on the next clock.
- **RUN**
  - On `tick_1s`, seconds (internal 0–59) increment.
  - 59→0 carries into minutes. Minutes 59→00 carries into hours. Hours 23→00.
  - `inc_p` is ignored.
- **SET_HOUR**
  - Time is frozen (`tick_1s` ignored).
  - `inc_p` advances hours modulo 24 (23→00). Minutes and seconds are untouched.
- **SET_MIN**
  - Time is frozen.
  - `inc_p` advances minutes modulo 60 (59→00) with no hour carry.
- **Arbitration**
  - `tick_1s` is applied only when the current (pre-edge) state is RUN. A tick in the same cycle as `mode_p` out of RUN is therefore applied.
  - If `mode_p` and `inc_p` occur in the same cycle, the mode change wins and the increment is dropped.
- **BCD rule:** every digit register always holds a legal value: hour10 ≤ 2; hour1 ≤ 3 when hour10 = 2; min10 ≤ 5; all digits ≤ 9.
- **Scan**
  - A 2-bit index advances 0→1→2→3→0 on each `tick_scan`.
  - `K` = 1110, 1101, 1011, 0111 for index 0–3 respectively.
  - `bcd` = min1, min10, hour1, hour10 for index 0–3 respectively.
- **Blink**
  - The blink phase toggles every `BLINK_SCANS` `tick_scan` pulses.
  - The phase counter and phase are forced to 0 (digits visible) on every state change and every accepted `inc_p`.
  - `blank` = 1 when phase = 1 and either (SET_HOUR and index ∈ {2,3}) or (SET_MIN and index ∈ {0,1}).
  - While `blank` = 1, `K` = 1111 and `bcd` keeps the digit value.

## Timing
- **Reset values** (asynchronous, immediate, any state):
  - mode = 00, time 00:00:00, index = 0, blink phase = 0.
  - Debounced levels = 0, synchronizers = 0.
  - Outputs: `bcd` = 0, `K` = 1110, `blank` = 0, all time digits 0.
- **Press latency**
  - Raw edge → 2 cycles of synchronization, then debounce acceptance on the `DB_TICKS`-th qualifying `tick_scan`.
  - The press pulse follows 1 cycle after acceptance.
  - State or time registers update on the clock edge that ends the pulse cycle.
- **Tick latency:** time registers update on the edge at the end of the `tick_1s` cycle, with a full carry chain in that same edge.
- **Display outputs**
  - `bcd`, `K` and `blank` are combinational decodes of the registered index, state, phase and time.
  - They change in the cycle after the register update.
- A button held high produces exactly one press; no auto-repeat.

## Test plan
- Reset, then 60 `tick_1s` pulses → min1 = 1, min10 = 0, hours 00; `K` cycles 1110, 1101, 1011, 0111 across 4 `tick_scan` pulses.
- Set the time to 23:59 via the SET path, return to RUN, then apply 60 `tick_1s` → 00:00, mode = 00.
- One mode press, then 25 inc presses with `tick_1s` running → mode = 01, hours = 01, minutes = 00, time frozen.
- `btn_inc` toggling on every `tick_scan` for 10 ticks, then held high for `DB_TICKS`+2 ticks → exactly one increment.
- In SET_MIN with no presses: after `BLINK_SCANS` scans, index 0/1 give `K` = 1111 with `blank` = 1 while index 2/3 remain 1011/0111. An inc press restores visibility immediately.
- In SET_HOUR, simultaneous mode and inc presses → mode = 10, hours unchanged. Asserting `reset` mid SET_MIN → same cycle mode = 00, time 00:00, `K` = 1110.
